// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and the
// load/store unit. Data requests normally win. After STARVE_LIMIT consecutive
// data wins against a waiting fetch, fetch is forced through. All outputs are
// registered. The memory request is held stable until m_ready is seen.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    // instruction fetch requester
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    // data load/store requester
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic [3:0]  d_size,
    output logic        d_ack,
    output logic [63:0] d_rdata,
    // unified memory port
    output logic        m_req,
    output logic        m_we,
    output logic [63:0] m_addr,
    output logic [63:0] m_wdata,
    output logic [3:0]  m_size,
    input  logic        m_ready,
    input  logic [63:0] m_rdata,
    // status
    output logic        busy,
    output logic        owner
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] starve_cnt;
    logic       grant_data;

    // Count of data wins against a pending fetch, clamped at the limit.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        if (v >= LIMIT) begin
            return LIMIT;
        end
        return v + 4'd1;
    endfunction

    // Data wins unless fetch has already lost LIMIT times in a row.
    always_comb begin
        grant_data = d_req && !(if_req && (starve_cnt == LIMIT));
    end

    // Arbitration FSM. The ack register is set when leaving ACCESS, so the
    // ack pulse is visible during the DONE cycle, and DONE returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_size     <= '0;
            busy       <= 1'b0;
            owner      <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        m_req <= 1'b1;
                        busy  <= 1'b1;
                        owner <= grant_data;
                        state <= ACCESS;
                        if (grant_data) begin
                            m_we    <= d_we;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            m_size  <= d_size;
                            if (if_req) begin
                                starve_cnt <= sat_inc(starve_cnt);
                            end
                        end else begin
                            m_we       <= 1'b0;
                            m_addr     <= if_addr;
                            m_wdata    <= '0;
                            m_size     <= 4'd4;
                            starve_cnt <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (m_ready) begin
                        m_req <= 1'b0;
                        state <= DONE;
                        if (owner) begin
                            d_ack   <= 1'b1;
                            d_rdata <= m_rdata;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= m_rdata[31:0];
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    m_req <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed transaction table, hand-written
// arbitration/reset sequences and a randomized run against a reference model.
module tb_mem_port_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [3:0]  d_size;
    logic        d_ack;
    logic [63:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [3:0]  m_size;
    logic        m_ready;
    logic [63:0] m_rdata;
    logic        busy;
    logic        owner;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size),
        .m_ready(m_ready), .m_rdata(m_rdata),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Directed single-requester transactions
    typedef struct {
        bit          is_data;
        logic [63:0] if_addr;
        bit          d_we;
        logic [63:0] d_addr;
        logic [63:0] d_wdata;
        logic [3:0]  d_size;
        int          waits;
        logic [63:0] rdata;
        logic [63:0] e_addr;
        bit          e_we;
        logic [63:0] e_wdata;
        logic [3:0]  e_size;
        logic [63:0] e_rdata;
    } vec_t;

    vec_t vecs[5];
    logic [31:0] exp_if_rd;
    logic [63:0] exp_d_rd;

    task automatic run_vec(input vec_t v, input int idx);
        string p;
        p = $sformatf("vec%0d", idx);
        if_req = !v.is_data; d_req = v.is_data;
        if_addr = v.if_addr; d_we = v.d_we; d_addr = v.d_addr;
        d_wdata = v.d_wdata; d_size = v.d_size; m_ready = 1'b0;
        step();
        for (int k = 0; k <= v.waits; k++) begin
            check1({p, " m_req"}, m_req, 1'b1);
            check1({p, " busy"}, busy, 1'b1);
            check1({p, " owner"}, owner, v.is_data);
            check({p, " m_addr"}, m_addr, v.e_addr);
            check1({p, " m_we"}, m_we, v.e_we);
            check({p, " m_wdata"}, m_wdata, v.e_wdata);
            check({p, " m_size"}, 64'(m_size), 64'(v.e_size));
            check1({p, " early if_ack"}, if_ack, 1'b0);
            check1({p, " early d_ack"}, d_ack, 1'b0);
            m_ready = (k == v.waits);
            m_rdata = (k == v.waits) ? v.rdata : ~v.rdata;
            step();
        end
        check1({p, " if_ack"}, if_ack, !v.is_data);
        check1({p, " d_ack"}, d_ack, v.is_data);
        check1({p, " m_req drop"}, m_req, 1'b0);
        if (v.is_data) begin
            exp_d_rd = v.e_rdata;
        end else begin
            exp_if_rd = v.e_rdata[31:0];
        end
        check({p, " if_rdata"}, 64'(if_rdata), 64'(exp_if_rd));
        check({p, " d_rdata"}, d_rdata, exp_d_rd);
        if_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
        step();
        check1({p, " busy end"}, busy, 1'b0);
        check1({p, " ack end"}, if_ack | d_ack, 1'b0);
    endtask

    // One zero-wait grant starting from IDLE with requests already driven.
    task automatic do_one(input bit exp_owner, input logic [63:0] rd, input bit drop, input string name);
        step();
        check1({name, " m_req"}, m_req, 1'b1);
        check1({name, " owner"}, owner, exp_owner);
        m_ready = 1'b1; m_rdata = rd;
        step();
        check1({name, " if_ack"}, if_ack, !exp_owner);
        check1({name, " d_ack"}, d_ack, exp_owner);
        if (exp_owner) check({name, " d_rdata"}, d_rdata, rd);
        else           check({name, " if_rdata"}, 64'(if_rdata), 64'(rd[31:0]));
        m_ready = 1'b0;
        if (drop) begin
            if (exp_owner) d_req = 1'b0;
            else           if_req = 1'b0;
        end
        step();
        check1({name, " idle"}, busy, 1'b0);
    endtask

    // Reference model: arbitration rules and handshake timing, cycle by cycle
    int          ph;
    int          starve;
    logic        e_mreq, e_we, e_busy, e_owner, e_ifack, e_dack;
    logic [63:0] e_addr, e_wdata, e_drd;
    logic [3:0]  e_size;
    logic [31:0] e_ifrd;

    task automatic model_step();
        bit dw;
        e_ifack = 1'b0; e_dack = 1'b0;
        if (rst) begin
            ph = 0; starve = 0; e_mreq = 0; e_we = 0; e_busy = 0; e_owner = 0;
            e_addr = 0; e_wdata = 0; e_size = 0; e_ifrd = 0; e_drd = 0;
            return;
        end
        if (ph == 0) begin
            if (if_req || d_req) begin
                dw = d_req && !(if_req && starve == STARVE_LIMIT);
                if (dw) begin
                    e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_size = d_size;
                    if (if_req) starve = (starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : starve + 1;
                end else begin
                    e_we = 1'b0; e_addr = if_addr; e_wdata = 64'd0; e_size = 4'd4;
                    starve = 0;
                end
                e_owner = dw; e_mreq = 1'b1; e_busy = 1'b1; ph = 1;
            end
        end else if (ph == 1) begin
            if (m_ready) begin
                e_mreq = 1'b0;
                if (e_owner) begin e_dack = 1'b1; e_drd = m_rdata; end
                else begin e_ifack = 1'b1; e_ifrd = m_rdata[31:0]; end
                ph = 2;
            end
        end else begin
            e_busy = 1'b0; ph = 0;
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 64'h40, 1'b1, 64'h999, 64'hAAAA, 4'd2, 0, 64'h8B02_0020,
                    64'h40, 1'b0, 64'h0, 4'd4, 64'h8B02_0020};
        vecs[1] = '{1'b1, 64'h0, 1'b1, 64'h100, 64'hDEAD, 4'd8, 3, 64'h0123_4567_89AB_CDEF,
                    64'h100, 1'b1, 64'hDEAD, 4'd8, 64'h0123_4567_89AB_CDEF};
        vecs[2] = '{1'b0, 64'h44, 1'b1, 64'h300, 64'h5555, 4'd8, 1, 64'hCAFE_BABE_F840_0020,
                    64'h44, 1'b0, 64'h0, 4'd4, 64'hF840_0020};
        vecs[3] = '{1'b1, 64'h48, 1'b0, 64'h200, 64'h0, 4'd8, 0, 64'h1234_5678_9ABC_DEF0,
                    64'h200, 1'b0, 64'h0, 4'd8, 64'h1234_5678_9ABC_DEF0};
        vecs[4] = '{1'b1, 64'h4C, 1'b0, 64'h7, 64'h77, 4'd1, 2, 64'h5A,
                    64'h7, 1'b0, 64'h77, 4'd1, 64'h5A};

        // reset state, with both requests high during reset
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1; if_addr = 64'h10; d_we = 1'b1;
        d_addr = 64'h20; d_wdata = 64'h30; d_size = 4'd8; m_ready = 1'b1; m_rdata = 64'hFF;
        step();
        step();
        check1("rst if_ack", if_ack, 1'b0);
        check1("rst d_ack", d_ack, 1'b0);
        check1("rst m_req", m_req, 1'b0);
        check1("rst m_we", m_we, 1'b0);
        check1("rst busy", busy, 1'b0);
        check1("rst owner", owner, 1'b0);
        check("rst m_addr", m_addr, 64'd0);
        check("rst m_wdata", m_wdata, 64'd0);
        check("rst m_size", 64'(m_size), 64'd0);
        check("rst if_rdata", 64'(if_rdata), 64'd0);
        check("rst d_rdata", d_rdata, 64'd0);
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
        exp_if_rd = '0; exp_d_rd = '0;
        step();

        // directed table
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], i);
        end

        // simultaneous requests: data first, then fetch
        do_reset();
        if_req = 1'b1; if_addr = 64'h400; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h800;
        step();
        check1("sim m_req", m_req, 1'b1);
        check1("sim owner data", owner, 1'b1);
        check("sim m_addr", m_addr, 64'h800);
        m_ready = 1'b1; m_rdata = 64'h11;
        step();
        check1("sim d_ack first", d_ack, 1'b1);
        check1("sim if_ack not yet", if_ack, 1'b0);
        d_req = 1'b0; m_ready = 1'b0;
        step();
        do_one(1'b0, 64'h22, 1'b1, "sim fetch second");

        // starvation guard
        do_reset();
        if_req = 1'b1; if_addr = 64'h500; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h600;
        for (int g = 0; g < STARVE_LIMIT; g++) begin
            do_one(1'b1, 64'(g + 100), 1'b0, $sformatf("starve data%0d", g));
        end
        do_one(1'b0, 64'h777, 1'b1, "starve forced fetch");
        if_req = 1'b1;
        do_one(1'b1, 64'h888, 1'b1, "starve count cleared");
        do_one(1'b0, 64'h999, 1'b1, "starve tail fetch");

        // reset while waiting in ACCESS
        if_req = 1'b1; if_addr = 64'hA0;
        step();
        check1("rstacc m_req", m_req, 1'b1);
        m_ready = 1'b0;
        step();
        rst = 1'b1; if_req = 1'b0;
        step();
        check1("rstacc m_req low", m_req, 1'b0);
        check1("rstacc busy low", busy, 1'b0);
        check1("rstacc no ack", if_ack | d_ack, 1'b0);
        rst = 1'b0;
        step();
        check1("rstacc still no ack", if_ack | d_ack, 1'b0);
        if_req = 1'b1; if_addr = 64'h80;
        do_one(1'b0, 64'h1111_2222, 1'b1, "post-reset fetch");

        // randomized run against the reference model
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk);
            model_step();
            #1;
            check1("rnd m_req", m_req, e_mreq);
            check1("rnd busy", busy, e_busy);
            check1("rnd owner", owner, e_owner);
            check1("rnd if_ack", if_ack, e_ifack);
            check1("rnd d_ack", d_ack, e_dack);
            check1("rnd m_we", m_we, e_we);
            check("rnd m_addr", m_addr, e_addr);
            check("rnd m_wdata", m_wdata, e_wdata);
            check("rnd m_size", 64'(m_size), 64'(e_size));
            check("rnd if_rdata", 64'(if_rdata), 64'(e_ifrd));
            check("rnd d_rdata", d_rdata, e_drd);
            rst = ($urandom % 150 == 0);
            if (if_ack) if_req = 1'b0;
            if (!if_req && ($urandom % 3 == 0)) begin
                if_req = 1'b1; if_addr = {$urandom, $urandom};
            end
            if (d_ack) d_req = 1'b0;
            if (!d_req && ($urandom % 3 == 0)) begin
                d_req = 1'b1; d_we = 1'($urandom); d_addr = {$urandom, $urandom};
                d_wdata = {$urandom, $urandom}; d_size = 4'($urandom);
            end
            m_ready = ($urandom % 3 == 0);
            m_rdata = {$urandom, $urandom};
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between instruction fetch and data load/store in the multi-cycle CPU. Each requester sees its own request/acknowledge handshake; the memory sees one registered request at a time, held stable until the memory signals ready. Data accesses have priority, with a bounded-starvation guard for fetch. The block sits between the fetch/LSU stages and the memory model.

## Interface
- STARVE_LIMIT, 4: number of consecutive data grants won against a pending fetch before fetch is forced to win; range 1..15.
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held high until if_ack
- if_addr  in  64  fetch byte address
- if_ack  out  1  one-cycle completion pulse for fetch
- if_rdata  out  32  fetched instruction, valid while if_ack=1
- d_req  in  1  data request; held high until d_ack
- d_we  in  1  1 = store (STUR), 0 = load (LDUR)
- d_addr  in  64  data byte address
- d_wdata  in  64  store data
- d_size  in  4  transfer size in bytes
- d_ack  out  1  one-cycle completion pulse for data
- d_rdata  out  64  load data, valid while d_ack=1
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_addr  out  64  memory address
- m_wdata  out  64  memory write data
- m_size  out  4  memory transfer size
- m_ready  in  1  memory completes the current access this cycle
- m_rdata  in  64  memory read data, valid when m_ready=1
- busy  out  1  state != IDLE
- owner  out  1  0 = fetch, 1 = data; meaningful only while busy

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if neither request is high, stay. Otherwise pick a winner:
  - Only one request high: that requester wins.
  - Both high: data wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - Latch the winner's fields into the transaction registers, set owner, go to ACCESS.
- Fetch transaction fields: m_we=0, m_addr=if_addr, m_wdata=0, m_size=4'd4.
- Data transaction fields: m_we=d_we, m_addr=d_addr, m_wdata=d_wdata, m_size=d_size.
- ACCESS: m_req=1 and all m_* outputs stay constant. When m_ready=1, capture m_rdata and go to DONE; otherwise stay. Wait time is unbounded.
- DONE: pulse the ack for the owner for exactly one cycle.
  - Fetch owner: if_rdata = captured[31:0].
  - Data owner: d_rdata = captured value. For stores, d_rdata is the captured m_rdata, which has no meaning.
  - Then go to IDLE. Requests are ignored in DONE.
- starve_cnt (4-bit):
  - Reset to 0 when fetch is granted.
  - Incremented, saturating at STARVE_LIMIT, when data is granted while if_req=1.
  - Unchanged when data is granted with if_req=0.
- Withdrawn request (req dropped before ack): this is a protocol violation. The arbiter still completes the memory access and pulses the ack.
- Outputs not described above hold their last value. if_rdata changes only on fetch completions; d_rdata changes only on data completions.

## Timing
- All outputs are registered.
- Reset values: if_ack=0, d_ack=0, m_req=0, m_we=0, busy=0, owner=0, starve_cnt=0, state=IDLE, and all data/address outputs 0.
- Zero-wait access (m_ready=1 in the first ACCESS cycle):
  - req sampled in cycle 0;
  - m_req high in cycle 1;
  - ack high in cycle 2;
  - IDLE in cycle 3.
- Latency with W wait cycles: ack in cycle 2+W.
- Maximum throughput is one transaction per 3 cycles. A requester may present a new request in the cycle after its ack; that request is sampled in IDLE.
- Simultaneous requests arriving in the same IDLE cycle are resolved as described in Operation; the loser stays pending and is arbitrated in the next IDLE.
- Reset mid-transaction takes effect at the next edge: state=IDLE, m_req=0, no ack is issued, and the access is abandoned. The memory model must tolerate m_req dropping without m_ready.
- m_ready outside ACCESS is ignored.

## Test plan
- Lone fetch, zero wait: if_addr=0x40, m_rdata=0x8B020020 -> m_req, m_addr=0x40, m_size=4 in cycle 1; if_ack=1 with if_rdata=0x8B020020 in cycle 2; busy=0 in cycle 3.
- Store with 3 wait cycles: d_we=1, d_addr=0x100, d_wdata=0xDEAD, d_size=8 -> m_we/m_addr/m_wdata stable for 4 cycles; d_ack in cycle 5; if_ack stays 0.
- Simultaneous requests, starve_cnt=0: data is granted first; fetch is granted in the following IDLE; acks arrive in order d_ack, then if_ack.
- Starvation guard, STARVE_LIMIT=4: if_req held high, d_req re-asserted after every ack -> 4 data grants, then 1 fetch grant; starve_cnt returns to 0.
- Reset in ACCESS with m_ready=0: next cycle m_req=0, busy=0, no ack; a fresh fetch afterward completes normally.
- Load after fetch: if_rdata keeps the fetch value while d_rdata=0x1234_5678_9ABC_DEF0 is delivered with d_ack.
